// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry instruction prefetch queue whose head entry is the
// architectural instruction register. Fetch pushes with il_in, decode pops
// with adv_in, and flush_in discards everything on a branch or redirect.
// The head word and its opcode/address/immediate fields are all registered,
// so nothing on the output side depends combinationally on ins_in.
// Optional build macro: IR_PARITY_EN adds a per-entry even-parity bit, the
// perr_out status output and the inj_perr_in injection input.
module ir_queue #(
  parameter int IW    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int IMMW  = 8,
  parameter int OPW   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       il_in,
  input  logic [IW-1:0]              ins_in,
  input  logic                       adv_in,
  input  logic                       flush_in,
`ifdef IR_PARITY_EN
  input  logic                       inj_perr_in,
  output logic                       perr_out,
`endif
  output logic                       rdy_out,
  output logic                       vld_out,
  output logic [IW-1:0]              ins_out,
  output logic [OPW-1:0]             op_out,
  output logic [IW-1:0]              ia_out,
  output logic [IW-1:0]              iv_out,
  output logic [$clog2(DEPTH+1)-1:0] cnt_out,
  output logic                       ovf_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [IW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;
  logic [IW-1:0]   r_ins;
  logic [OPW-1:0]  r_op;
  logic [IW-1:0]   r_ia;
  logic [IW-1:0]   r_iv;

  logic            w_rdy;
  logic            w_vld;
  logic            w_push;
  logic            w_pop;
  logic [PW-1:0]   w_nextPtr;
  logic            w_loadHead;
  logic [IW-1:0]   w_nextHead;
  logic [CW-1:0]   w_nextCnt;
  logic [OPW-1:0]  w_nextOp;
  logic [IW-1:0]   w_nextIa;
  logic [IW-1:0]   w_nextIv;

`ifdef IR_PARITY_EN
  logic            r_par [DEPTH];
  logic            r_headPar;
  logic            r_perr;
  logic            w_pushPar;
  logic            w_nextPar;
`endif

  assign w_rdy     = (r_cnt < CW'(DEPTH));
  assign w_vld     = (r_cnt != '0);
  assign w_push    = il_in && w_rdy;
  assign w_pop     = adv_in && w_vld;
  assign w_nextPtr = r_rptr + PW'(1);

  assign rdy_out = w_rdy;
  assign vld_out = w_vld;
  assign ins_out = r_ins;
  assign op_out  = r_op;
  assign ia_out  = r_ia;
  assign iv_out  = r_iv;
  assign cnt_out = r_cnt;
  assign ovf_out = r_ovf;

`ifdef IR_PARITY_EN
  assign w_pushPar = (^ins_in) ^ inj_perr_in;
  assign perr_out  = r_perr;
`endif

  // Decide what the head register shows next cycle: the entry behind the
  // current head after a pop, or the incoming word when it lands on an
  // empty (or emptying) queue; otherwise the head simply holds.
  always_comb begin
    w_loadHead = 1'b0;
    w_nextHead = r_ins;
`ifdef IR_PARITY_EN
    w_nextPar  = r_headPar;
`endif
    if (!flush_in) begin
      if (w_pop) begin
        if (r_cnt > CW'(1)) begin
          w_loadHead = 1'b1;
          w_nextHead = r_mem[w_nextPtr];
`ifdef IR_PARITY_EN
          w_nextPar  = r_par[w_nextPtr];
`endif
        end else if (w_push) begin
          w_loadHead = 1'b1;
          w_nextHead = ins_in;
`ifdef IR_PARITY_EN
          w_nextPar  = w_pushPar;
`endif
        end
      end else if (!w_vld && w_push) begin
        w_loadHead = 1'b1;
        w_nextHead = ins_in;
`ifdef IR_PARITY_EN
        w_nextPar  = w_pushPar;
`endif
      end
    end
  end

  // Occupancy after this edge; flush wins over any push or pop.
  always_comb begin
    w_nextCnt = r_cnt;
    if (flush_in) begin
      w_nextCnt = '0;
    end else if (w_push && !w_pop) begin
      w_nextCnt = r_cnt + CW'(1);
    end else if (w_pop && !w_push) begin
      w_nextCnt = r_cnt - CW'(1);
    end
  end

  // Field decode of the word about to become the head.
  always_comb begin
    w_nextOp = w_nextHead[IW-1 -: OPW];
    w_nextIa = {{(IW-AW){1'b0}}, w_nextHead[AW-1:0]};
    w_nextIv = {{(IW-IMMW){w_nextHead[IMMW-1]}}, w_nextHead[IMMW-1:0]};
  end

  // Entry storage: write the pushed word at the tail slot.
  always_ff @(posedge clk) begin
    if (w_push && !flush_in) begin
      r_mem[r_wptr] <= ins_in;
`ifdef IR_PARITY_EN
      r_par[r_wptr] <= w_pushPar;
`endif
    end
  end

  // Pointers, count and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else if (flush_in) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_cnt <= w_nextCnt;
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= w_nextPtr;
      end
      if (il_in && !w_rdy) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Head register and its pre-decoded fields, loaded together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ins <= '0;
      r_op  <= '0;
      r_ia  <= '0;
      r_iv  <= '0;
    end else if (w_loadHead) begin
      r_ins <= w_nextHead;
      r_op  <= w_nextOp;
      r_ia  <= w_nextIa;
      r_iv  <= w_nextIv;
    end
  end

`ifdef IR_PARITY_EN
  // Head parity and the error flag, which only means something while a
  // valid instruction sits in the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_headPar <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_headPar <= w_nextPar;
      r_perr    <= (w_nextCnt != '0) && ((^w_nextHead) != w_nextPar);
    end
  end
`endif

endmodule

// File: tb/tb_ir_queue.sv
// Testbench for ir_queue: directed steps from the block's test plan followed
// by a randomized phase, all checked against a queue-based reference model.
module tb_ir_queue;

  localparam int IW    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int IMMW  = 8;
  localparam int OPW   = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          ilIn;
  logic [IW-1:0] insIn;
  logic          advIn;
  logic          flushIn;
  logic          rdyOut;
  logic          vldOut;
  logic [IW-1:0] insOut;
  logic [OPW-1:0] opOut;
  logic [IW-1:0] iaOut;
  logic [IW-1:0] ivOut;
  logic [CW-1:0] cntOut;
  logic          ovfOut;
`ifdef IR_PARITY_EN
  logic          injPerr;
  logic          perrOut;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  logic [IW-1:0] modelQ[$];
  logic [IW-1:0] modelHead;
  logic          modelOvf;

  ir_queue #(.IW(IW), .DEPTH(DEPTH), .AW(AW), .IMMW(IMMW), .OPW(OPW)) dut (
    .clk(clk),
    .rst(rst),
    .il_in(ilIn),
    .ins_in(insIn),
    .adv_in(advIn),
    .flush_in(flushIn),
`ifdef IR_PARITY_EN
    .inj_perr_in(injPerr),
    .perr_out(perrOut),
`endif
    .rdy_out(rdyOut),
    .vld_out(vldOut),
    .ins_out(insOut),
    .op_out(opOut),
    .ia_out(iaOut),
    .iv_out(ivOut),
    .cnt_out(cntOut),
    .ovf_out(ovfOut)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference model's view of the queue.
  task automatic checkOutput(input string tag);
    int unsigned low;
    logic [31:0] expIv;
    low   = int'(modelHead) % (1 << IMMW);
    expIv = (low >= (1 << (IMMW - 1))) ? (low + (1 << IW) - (1 << IMMW)) : low;
    checkVal({tag, ".cnt"}, 32'(cntOut), 32'(modelQ.size()));
    checkVal({tag, ".vld"}, 32'(vldOut), 32'(modelQ.size() > 0));
    checkVal({tag, ".rdy"}, 32'(rdyOut), 32'(modelQ.size() < DEPTH));
    checkVal({tag, ".ovf"}, 32'(ovfOut), 32'(modelOvf));
    checkVal({tag, ".ins"}, 32'(insOut), 32'(modelHead));
    checkVal({tag, ".op"},  32'(opOut),  32'(int'(modelHead) / (1 << (IW - OPW))));
    checkVal({tag, ".ia"},  32'(iaOut),  32'(int'(modelHead) % (1 << AW)));
    checkVal({tag, ".iv"},  32'(ivOut),  expIv);
  endtask

  // Drive one cycle of inputs, advance the model by the queue rules, then
  // sample the DUT 1 time unit after the rising edge.
  task automatic applyStimulus(input logic il, input logic [IW-1:0] w,
                               input logic adv, input logic fl, input string tag);
    bit canPush;
    bit canPop;
    ilIn    = il;
    insIn   = w;
    advIn   = adv;
    flushIn = fl;
    canPush = il && (modelQ.size() < DEPTH);
    canPop  = adv && (modelQ.size() > 0);
    if (fl) begin
      modelQ.delete();
      modelOvf = 1'b0;
    end else begin
      if (il && !canPush) modelOvf = 1'b1;
      if (canPop) void'(modelQ.pop_front());
      if (canPush) modelQ.push_back(w);
      if (modelQ.size() > 0) modelHead = modelQ[0];
    end
    @(posedge clk);
    #1;
    ilIn    = 1'b0;
    advIn   = 1'b0;
    flushIn = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    rst     = 1'b1;
    ilIn    = 1'b0;
    insIn   = '0;
    advIn   = 1'b0;
    flushIn = 1'b0;
`ifdef IR_PARITY_EN
    injPerr = 1'b0;
`endif
    modelHead = '0;
    modelOvf  = 1'b0;

    // Reset state
    #3;
    checkOutput("reset");
    rst = 1'b0;
    @(negedge clk);

    // Push into empty, check head and field decode
    applyStimulus(1'b1, 16'hA5F3, 1'b0, 1'b0, "pushEmpty");
    checkVal("pushEmpty.insConst", 32'(insOut), 32'h0000A5F3);
    checkVal("pushEmpty.opConst",  32'(opOut),  32'hA);
    checkVal("pushEmpty.iaConst",  32'(iaOut),  32'h000000F3);
    checkVal("pushEmpty.ivConst",  32'(ivOut),  32'h0000FFF3);
    checkVal("pushEmpty.cntConst", 32'(cntOut), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, "drain");

    // Fill to DEPTH, then overflow
    applyStimulus(1'b1, 16'h1001, 1'b0, 1'b0, "fill1");
    applyStimulus(1'b1, 16'h2002, 1'b0, 1'b0, "fill2");
    applyStimulus(1'b1, 16'h3003, 1'b0, 1'b0, "fill3");
    applyStimulus(1'b1, 16'h4004, 1'b0, 1'b0, "fill4");
    checkVal("full.cnt", 32'(cntOut), 32'd4);
    checkVal("full.rdy", 32'(rdyOut), 32'd0);
    applyStimulus(1'b1, 16'h5005, 1'b0, 1'b0, "overflow");
    checkVal("overflow.ovf", 32'(ovfOut), 32'd1);
    checkVal("overflow.cnt", 32'(cntOut), 32'd4);

    // Drain in order
    checkVal("order.head0", 32'(insOut), 32'h1001);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, "pop1");
    checkVal("order.head1", 32'(insOut), 32'h2002);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, "pop2");
    checkVal("order.head2", 32'(insOut), 32'h3003);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, "pop3");
    checkVal("order.head3", 32'(insOut), 32'h4004);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, "pop4");
    checkVal("order.empty", 32'(vldOut), 32'd0);

    // Simultaneous push and pop with one entry
    applyStimulus(1'b1, 16'h0107, 1'b0, 1'b0, "single");
    applyStimulus(1'b1, 16'h0280, 1'b1, 1'b0, "pushPop");
    checkVal("pushPop.ins", 32'(insOut), 32'h0280);
    checkVal("pushPop.cnt", 32'(cntOut), 32'd1);
    checkVal("pushPop.iv",  32'(ivOut),  32'hFF80);

    // Flush beats push and pop, head word holds
    applyStimulus(1'b1, 16'h0311, 1'b0, 1'b0, "pre1");
    applyStimulus(1'b1, 16'h0422, 1'b0, 1'b0, "pre2");
    checkVal("preFlush.ovf", 32'(ovfOut), 32'd1);
    applyStimulus(1'b1, 16'h0533, 1'b1, 1'b1, "flush");
    checkVal("flush.cnt", 32'(cntOut), 32'd0);
    checkVal("flush.ovf", 32'(ovfOut), 32'd0);
    checkVal("flush.rdy", 32'(rdyOut), 32'd1);
    checkVal("flush.ins", 32'(insOut), 32'h0280);

    // Asynchronous reset mid-cycle
    applyStimulus(1'b1, 16'h0A0A, 1'b0, 1'b0, "arPre1");
    applyStimulus(1'b1, 16'h0B0B, 1'b0, 1'b0, "arPre2");
    #2;
    rst = 1'b1;
    modelQ.delete();
    modelHead = '0;
    modelOvf  = 1'b0;
    #1;
    checkOutput("asyncReset");
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, "advEmpty");

`ifdef IR_PARITY_EN
    // Injected parity error follows its word through the head
    injPerr = 1'b1;
    applyStimulus(1'b1, 16'h00FF, 1'b0, 1'b0, "parBad");
    injPerr = 1'b0;
    checkVal("parBad.perr", 32'(perrOut), 32'd1);
    applyStimulus(1'b1, 16'h00FE, 1'b0, 1'b0, "parGood");
    checkVal("parGood.perrHeld", 32'(perrOut), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, "parAdv");
    checkVal("parAdv.perr", 32'(perrOut), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, "parFlush");
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 55), 16'($urandom),
                    1'($urandom_range(0, 99) < 45),
                    1'($urandom_range(0, 99) < 4), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
